// File: rtl/roulette_pkg.sv
// Shared types and default timing constants for the roulette front end.
package roulette_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    HELD_LONG,
    DB_RELEASE
  } btn_state_t;

  localparam int CLK_HZ             = 100_000_000;
  localparam int DEBOUNCE_DEFAULT   = CLK_HZ / 100;
  localparam int LONG_PRESS_DEFAULT = CLK_HZ;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flip-flop synchronizer for bringing one asynchronous pad bit into the clk domain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: synchronize, debounce press/release, and emit clean level plus
// single-cycle press, release and long-press strobes.
module button_conditioner
  import roulette_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW  = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_FIRST  = DBW'(1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic s;

  btn_state_t state, state_n;
  logic [DBW-1:0] db_cnt, db_cnt_n, db_inc;
  logic [HW-1:0]  hold_cnt, hold_cnt_n, hold_inc;
  logic long_done, long_done_n;
  logic press_evt, release_evt, long_evt;
  logic press_evt_n, release_evt_n, long_evt_n;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (button_raw),
    .q  (s)
  );

  // Both counters saturate so a stuck input can never wrap them into a false match.
  assign db_inc   = (db_cnt == '1)   ? db_cnt   : db_cnt + 1'b1;
  assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
    end else begin
      state       <= state_n;
      db_cnt      <= db_cnt_n;
      hold_cnt    <= hold_cnt_n;
      long_done   <= long_done_n;
      press_evt   <= press_evt_n;
      release_evt <= release_evt_n;
      long_evt    <= long_evt_n;
    end
  end

  always_comb begin
    state_n       = state;
    db_cnt_n      = db_cnt;
    hold_cnt_n    = hold_cnt;
    long_done_n   = long_done;
    press_evt_n   = 1'b0;
    release_evt_n = 1'b0;
    long_evt_n    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_n  = DB_PRESS;
          db_cnt_n = DB_FIRST;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          state_n = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n     = PRESSED;
          press_evt_n = 1'b1;
          hold_cnt_n  = '0;
        end else begin
          db_cnt_n = db_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n     = DB_RELEASE;
          db_cnt_n    = DB_FIRST;
          long_done_n = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n    = HELD_LONG;
          long_evt_n = 1'b1;
        end else begin
          hold_cnt_n = hold_inc;
        end
      end
      HELD_LONG: begin
        if (!s) begin
          state_n     = DB_RELEASE;
          db_cnt_n    = DB_FIRST;
          long_done_n = 1'b1;
        end
      end
      DB_RELEASE: begin
        // A bounce drops back to where we came from; hold_cnt was frozen meanwhile.
        if (s) begin
          state_n = long_done ? HELD_LONG : PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_n       = IDLE;
          release_evt_n = 1'b1;
        end else begin
          db_cnt_n = db_inc;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output stage keeps the level aligned with the strobes it accompanies.
  always_ff @(posedge clk) begin
    if (rst) begin
      button_level     <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      button_level     <= (state == PRESSED) || (state == HELD_LONG) || (state == DB_RELEASE);
      press_pulse      <= press_evt;
      release_pulse    <= release_evt;
      long_press_pulse <= long_evt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/long-press settings.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic button_raw;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  int cyc;
  int compared;
  int mismatched;

  // Pulse encoding {long, release, press}; output encoding {level, long, release, press}.
  localparam logic [2:0] EV_PRESS   = 3'b001;
  localparam logic [2:0] EV_RELEASE = 3'b010;
  localparam logic [2:0] EV_LONG    = 3'b100;

  typedef struct {
    int         cycle;
    logic [3:0] val;
  } exp_t;

  exp_t evq[$];
  exp_t outq[$];

  button_conditioner #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .button_raw      (button_raw),
    .button_level    (button_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic expectEvent(input int c, input logic [2:0] kind);
    evq.push_back('{c, {1'b0, kind}});
  endtask

  task automatic expectOutputs(input int c, input logic [3:0] v);
    outq.push_back('{c, v});
  endtask

  // Advance to just after clock edge c, then drive the inputs.
  task automatic applyStimulus(input int c, input logic r, input logic raw);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    rst        = r;
    button_raw = raw;
  endtask

  // Monitor: every observed pulse must match the head of the event queue, in kind and cycle.
  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t e;
    obs = {long_press_pulse, release_pulse, press_pulse};
    if (obs != 3'b000) begin
      if (evq.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, obs}, 32'd0);
      end else begin
        e = evq.pop_front();
        checkOutput("pulse_kind", {29'd0, obs}, {28'd0, e.val});
        checkOutput("pulse_cycle", cyc, e.cycle);
      end
    end else if (evq.size() != 0 && evq[0].cycle <= cyc) begin
      e = evq.pop_front();
      checkOutput("missed_pulse", 32'd0, {28'd0, e.val});
    end
    if (outq.size() != 0 && outq[0].cycle <= cyc) begin
      e = outq.pop_front();
      checkOutput((e.cycle == cyc) ? "outputs" : "outputs_late", {28'd0, button_level, obs},
                  {28'd0, e.val});
    end
  end

  initial begin
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    button_raw = 1'b1;

    // Reset held three edges with the button already down, then a full debounce.
    expectOutputs(1, 4'b0000);
    expectOutputs(2, 4'b0000);
    expectOutputs(3, 4'b0000);
    applyStimulus(3, 1'b0, 1'b1);
    expectOutputs(9, 4'b0000);
    expectEvent(10, EV_PRESS);
    expectOutputs(10, 4'b1001);
    expectOutputs(11, 4'b1000);
    applyStimulus(15, 1'b0, 1'b0);
    expectOutputs(21, 4'b1000);
    expectEvent(22, EV_RELEASE);
    expectOutputs(22, 4'b0010);

    // Glitch: three high cycles are one short of acceptance.
    applyStimulus(30, 1'b0, 1'b1);
    applyStimulus(33, 1'b0, 1'b0);
    expectOutputs(36, 4'b0000);
    expectOutputs(38, 4'b0000);
    expectOutputs(40, 4'b0000);

    // Short press of twelve cycles.
    applyStimulus(50, 1'b0, 1'b1);
    expectOutputs(56, 4'b0000);
    expectEvent(57, EV_PRESS);
    expectOutputs(57, 4'b1001);
    expectOutputs(58, 4'b1000);
    applyStimulus(62, 1'b0, 1'b0);
    expectOutputs(68, 4'b1000);
    expectEvent(69, EV_RELEASE);
    expectOutputs(69, 4'b0010);
    expectOutputs(70, 4'b0000);

    // Long press of forty cycles.
    applyStimulus(80, 1'b0, 1'b1);
    expectEvent(87, EV_PRESS);
    expectOutputs(87, 4'b1001);
    expectOutputs(106, 4'b1000);
    expectEvent(107, EV_LONG);
    expectOutputs(107, 4'b1100);
    expectOutputs(108, 4'b1000);
    applyStimulus(120, 1'b0, 1'b0);
    expectOutputs(126, 4'b1000);
    expectEvent(127, EV_RELEASE);
    expectOutputs(127, 4'b0010);

    // Release with a one-cycle bounce: 0,0,1,0,0,...
    applyStimulus(140, 1'b0, 1'b1);
    expectEvent(147, EV_PRESS);
    expectOutputs(147, 4'b1001);
    applyStimulus(152, 1'b0, 1'b0);
    expectOutputs(156, 4'b1000);
    expectOutputs(157, 4'b1000);
    expectOutputs(158, 4'b1000);
    expectOutputs(161, 4'b1000);
    applyStimulus(154, 1'b0, 1'b1);
    applyStimulus(155, 1'b0, 1'b0);
    expectEvent(162, EV_RELEASE);
    expectOutputs(162, 4'b0010);

    // Reset for one cycle while held: silent drop, then a fresh press.
    applyStimulus(180, 1'b0, 1'b1);
    expectEvent(187, EV_PRESS);
    expectOutputs(187, 4'b1001);
    applyStimulus(192, 1'b1, 1'b1);
    expectOutputs(192, 4'b1000);
    expectOutputs(193, 4'b0000);
    expectOutputs(194, 4'b0000);
    applyStimulus(193, 1'b0, 1'b1);
    expectOutputs(199, 4'b0000);
    expectEvent(200, EV_PRESS);
    expectOutputs(200, 4'b1001);
    applyStimulus(205, 1'b0, 1'b0);
    expectEvent(212, EV_RELEASE);
    expectOutputs(212, 4'b0010);

    applyStimulus(230, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("event_queue_drained", evq.size(), 32'd0);
    checkOutput("output_queue_drained", outq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
